// File: rtl/regfile_access_ctrl.sv
// Request-side controller for a register-file word array: accepts write / dual-read
// requests, drives one-hot row strobes for one cycle and returns read data over a response channel.
module regfile_access_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr_w,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AW-1:0]    req_addr_a,
    input  logic [AW-1:0]    req_addr_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data_a,
    output logic [WIDTH-1:0] rsp_data_b,
    output logic             rsp_err,
    output logic [DEPTH-1:0] rf_write_select,
    output logic [WIDTH-1:0] rf_data_o,
    output logic [DEPTH-1:0] rf_read_a,
    output logic [DEPTH-1:0] rf_read_b,
    input  logic [WIDTH-1:0] rf_out_a,
    input  logic [WIDTH-1:0] rf_out_b
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic [DEPTH-1:0] r_write_select;
    logic [WIDTH-1:0] r_data_o;
    logic [DEPTH-1:0] r_read_a;
    logic [DEPTH-1:0] r_read_b;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data_a;
    logic [WIDTH-1:0] r_rsp_data_b;
    logic             r_rsp_err;

    logic [DEPTH-1:0] w_sel_w;
    logic [DEPTH-1:0] w_sel_a;
    logic [DEPTH-1:0] w_sel_b;

    // Out-of-range addresses match no row, so their decode is simply all-zero.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign w_sel_w[gi] = (req_addr_w == AW'(gi));
            assign w_sel_a[gi] = (req_addr_a == AW'(gi));
            assign w_sel_b[gi] = (req_addr_b == AW'(gi));
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b1;
            r_write_select <= '0;
            r_data_o       <= '0;
            r_read_a       <= '0;
            r_read_b       <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data_a   <= '0;
            r_rsp_data_b   <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        if (req_write) begin
                            r_write_select <= w_sel_w;
                            r_data_o       <= req_data;
                            r_state        <= S_WRITE;
                        end else begin
                            r_read_a <= w_sel_a;
                            r_read_b <= w_sel_b;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    r_write_select <= '0;
                    r_req_ready    <= 1'b1;
                    r_state        <= S_IDLE;
                end
                S_READ: begin
                    // An empty enable vector marks an out-of-range port.
                    r_read_a     <= '0;
                    r_read_b     <= '0;
                    r_rsp_data_a <= (|r_read_a) ? rf_out_a : '0;
                    r_rsp_data_b <= (|r_read_b) ? rf_out_b : '0;
                    r_rsp_err    <= ~(|r_read_a) | ~(|r_read_b);
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign rf_write_select = r_write_select;
    assign rf_data_o       = r_data_o;
    assign rf_read_a       = r_read_a;
    assign rf_read_b       = r_read_b;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data_a      = r_rsp_data_a;
    assign rsp_data_b      = r_rsp_data_b;
    assign rsp_err         = r_rsp_err;

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator/controller side of the register-file word array.
- Accepts write and dual-read requests over a valid/ready interface.
- Decodes addresses into one-hot write-select and read-enable strobes for the word rows, drives write data, captures the shared OutA/OutB buses, and returns read results over a valid/ready response channel.
- Sits between the datapath/decoder and the array of register-file words.

Parameters:
WIDTH, 32, data width of each word and of all data buses
DEPTH, 32, number of words in the array (one strobe bit per word)
AW, 5, address width; must satisfy 2**AW >= DEPTH

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_write  input  1  1 = write request, 0 = dual-read request
req_addr_w  input  AW  write address
req_data  input  WIDTH  write data
req_addr_a  input  AW  read address, port A
req_addr_b  input  AW  read address, port B
rsp_valid  output  1  read response present
rsp_ready  input  1  consumer accepts response
rsp_data_a  output  WIDTH  port A read data
rsp_data_b  output  WIDTH  port B read data
rsp_err  output  1  at least one read address was >= DEPTH
rf_write_select  output  DEPTH  one-hot write strobe, one bit per word
rf_data_o  output  WIDTH  write data to all words
rf_read_a  output  DEPTH  one-hot port-A read enable
rf_read_b  output  DEPTH  one-hot port-B read enable
rf_out_a  input  WIDTH  shared port-A bus from the words
rf_out_b  input  WIDTH  shared port-B bus from the words

Behaviour:
- Reset (Rst_n low, asynchronous):
  - FSM to IDLE.
  - All strobes/enables 0; rf_data_o = 0.
  - rsp_valid = 0; rsp_data_a/b = 0; rsp_err = 0.
  - Any in-flight request or pending response is discarded.
- Reset release: req_ready = 1 in the first cycle.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready = 1. All other states: req_ready = 0.
  - Handshake completes on a rising edge with req_valid & req_ready.
  - Accepted request registers all request fields.
  - req_write = 1 -> WRITE; req_write = 0 -> READ.
- WRITE (exactly 1 cycle):
  - rf_write_select = one-hot of the registered write address.
  - rf_data_o = registered data.
  - Next state IDLE.
  - Address >= DEPTH: rf_write_select = 0 (write silently dropped, no error report).
  - rf_data_o keeps its value after WRITE; only a new write or reset changes it.
- READ (exactly 1 cycle):
  - rf_read_a / rf_read_b = one-hot of the registered addresses.
  - Address A equal to address B is legal; both enables assert on the same word.
  - At the closing edge: rsp_data_a <= rf_out_a and rsp_data_b <= rf_out_b.
  - A port whose address is >= DEPTH: its enable stays 0, its data captures 0, and rsp_err <= 1.
  - Next state RESP.
- RESP:
  - rsp_valid = 1; rsp_data_a/b and rsp_err held stable until rsp_valid & rsp_ready at a rising edge, then IDLE.
  - If rsp_ready is already high on entry, the response completes at the first RESP edge.
- Strobe rules:
  - rf_read_a/b are 0 in every state except READ; the rf_out buses are don't-care and never sampled elsewhere.
  - rf_write_select is 0 in every state except WRITE.
  - No cycle ever has write and read strobes active together.
- Latency and throughput:
  - Write accepted at edge N -> strobe during cycle N..N+1 -> req_ready again after edge N+1 (1 write per 2 cycles).
  - Read accepted at edge N -> READ in cycle N..N+1 -> rsp_valid after edge N+1.
  - Best-case read occupancy is 3 cycles.
- Write-then-read to the same address: the read returns the new value, because the write edge precedes the READ cycle.
- rsp_data_a/b are 0 after reset and keep their last captured value after the handshake.

Test Plan:
1. Reset mid-read (Rst_n low during READ) -> all strobes 0 immediately (asynchronous); after release rsp_valid = 0, rsp_data_a/b = 0, req_ready = 1; no response appears.
2. Write addr 5 data 0xDEADBEEF -> one cycle with rf_write_select = 0x00000020 and rf_data_o = 0xDEADBEEF; req_ready low for exactly that cycle.
3. After test 2, read A = 5, B = 0 with rf model returning stored values -> rf_read_a = 0x20, rf_read_b = 0x1 for one cycle; rsp_data_a = 0xDEADBEEF, rsp_data_b = 0, rsp_err = 0.
4. Read A = B = 7 with rsp_ready held low for 4 cycles -> rsp_valid high and data stable for all 4 cycles; IDLE one cycle after rsp_ready rises.
5. DEPTH = 20: write addr 25 -> rf_write_select = 0 throughout; read A = 25, B = 3 -> rf_read_a = 0, rsp_data_a = 0, rsp_err = 1, rsp_data_b = word 3 contents.
6. Back-to-back requests with req_valid held high (W3, R3/3, W4) -> req_ready pattern 1,0,1,0,0,1,…; strobes never overlap; read returns the value from W3.
